// File: rtl/ecu_gpio_bank.sv
// ecu_gpio_bank: parametrised GPIO bank on an Avalon-MM slave.
// Provides per-pin direction, atomic set/clear of outputs, input synchronisation,
// rising/falling edge capture with write-1-to-clear and a registered level irq.
// Optional feature macro: ECU_GPIO_DEBOUNCE_EN adds a per-pin debounce filter
// between the synchroniser and the edge detector.
`default_nettype none

module ecu_gpio_bank #(
  parameter int WIDTH           = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  input  logic [WIDTH-1:0] gpio_r_export,
  output logic [WIDTH-1:0] gpio_w_export,
  output logic [WIDTH-1:0] gpio_dir_export,
  output logic             irq
);

  typedef enum logic [2:0] {
    ADDR_DATA_IN  = 3'd0,
    ADDR_DATA_OUT = 3'd1,
    ADDR_DIR      = 3'd2,
    ADDR_SET      = 3'd3,
    ADDR_CLR      = 3'd4,
    ADDR_RISE_EN  = 3'd5,
    ADDR_FALL_EN  = 3'd6,
    ADDR_EDGE_CAP = 3'd7
  } reg_addr_e;

`ifdef ECU_GPIO_DEBOUNCE_EN
  localparam bit DEBOUNCE_EN = 1'b1;
`else
  localparam bit DEBOUNCE_EN = 1'b0;
`endif

  // Edge detection stays disarmed until the synchroniser (and the debounce
  // filter, when present) has flushed its reset zeros, so a pin that is already
  // high when reset releases does not look like a rising edge.
  localparam int ARM_CYCLES = SYNC_STAGES + 1 + (DEBOUNCE_EN ? DEBOUNCE_CYCLES : 0);
  localparam int ARM_W      = $clog2(ARM_CYCLES + 1);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_CYCLES);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] capture;
  logic [WIDTH-1:0] wdata;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q;
  logic [ARM_W-1:0] arm_cnt_q;
  logic             armed;

  assign wdata = avs_writedata[WIDTH-1:0];
  assign s     = sync_q[SYNC_STAGES-1];
  assign armed = (arm_cnt_q == ARM_LAST);

  // Input synchroniser chain; pads are asynchronous to clk_clk.
  // NOTE: every flop uses <= so all stages sample the old value of the stage before;
  // blocking assignments here would collapse the chain into a single flop.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_r_export;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef ECU_GPIO_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0]  db_cnt_q [WIDTH];
  logic [WIDTH-1:0] filt_q;

  // Per-pin debounce: f follows s only after DEBOUNCE_CYCLES consecutive mismatches.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      filt_q <= '0;
      for (int i = 0; i < WIDTH; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s[i] == filt_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          filt_q[i]   <= s[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign f = filt_q;
`else
  assign f = s;
`endif

  // Qualified edges; nothing is captured until the input path has settled.
  always_comb begin
    capture = '0;
    if (armed) capture = (f & ~p_q & rise_en_q) | (~f & p_q & fall_en_q);
  end

  // Register write decode; one register is written per cycle, so SET and CLR
  // can never collide. A fresh capture beats a same-cycle write-1-to-clear.
  // NOTE: each _d gets its hold value first so no path through the case leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    edge_clr   = '0;
    if (avs_write) begin
      case (reg_addr_e'(avs_address))
        ADDR_DATA_OUT: data_out_d = wdata;
        ADDR_DIR:      dir_d      = wdata;
        ADDR_SET:      data_out_d = data_out_q | wdata;
        ADDR_CLR:      data_out_d = data_out_q & ~wdata;
        ADDR_RISE_EN:  rise_en_d  = wdata;
        ADDR_FALL_EN:  fall_en_d  = wdata;
        ADDR_EDGE_CAP: edge_clr   = wdata;
        default:       ;
      endcase
    end
    edge_cap_d = (edge_cap_q & ~edge_clr) | capture;
  end

  // Read mux; bits at and above WIDTH stay zero, SET/CLR read as zero.
  always_comb begin
    readdata_d = '0;
    case (reg_addr_e'(avs_address))
      ADDR_DATA_IN:  readdata_d[WIDTH-1:0] = f;
      ADDR_DATA_OUT: readdata_d[WIDTH-1:0] = data_out_q;
      ADDR_DIR:      readdata_d[WIDTH-1:0] = dir_q;
      ADDR_RISE_EN:  readdata_d[WIDTH-1:0] = rise_en_q;
      ADDR_FALL_EN:  readdata_d[WIDTH-1:0] = fall_en_q;
      ADDR_EDGE_CAP: readdata_d[WIDTH-1:0] = edge_cap_q;
      default:       readdata_d = '0;
    endcase
  end

  // Control/status registers, previous-value register and arming counter.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      data_out_q <= '0;
      dir_q      <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      edge_cap_q <= '0;
      p_q        <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
      arm_cnt_q  <= '0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      edge_cap_q <= edge_cap_d;
      p_q        <= f;
      irq_q      <= |edge_cap_q;
      if (avs_read) readdata_q <= readdata_d;
      if (!armed)   arm_cnt_q  <= arm_cnt_q + 1'b1;
    end
  end

  assign avs_readdata    = readdata_q;
  assign gpio_w_export   = data_out_q;
  assign gpio_dir_export = dir_q;
  assign irq             = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_ecu_gpio_bank.sv
// tb_ecu_gpio_bank: directed bench for ecu_gpio_bank with WIDTH=8, SYNC_STAGES=2.
// Cycle-exact expectations include the debounce delay when ECU_GPIO_DEBOUNCE_EN is set.
`default_nettype none

module tb_ecu_gpio_bank;

`ifdef ECU_GPIO_DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 0;
`endif
  localparam int SETTLE = 6 + DB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic [7:0]  gpio_r = 8'hFF;
  logic [7:0]  gpio_w;
  logic [7:0]  gpio_dir;
  logic        irq;

  int n_chk  = 0;
  int n_pass = 0;

  ecu_gpio_bank #(
    .WIDTH(8),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .avs_address    (avs_address),
    .avs_read       (avs_read),
    .avs_write      (avs_write),
    .avs_writedata  (avs_writedata),
    .avs_readdata   (avs_readdata),
    .gpio_r_export  (gpio_r),
    .gpio_w_export  (gpio_w),
    .gpio_dir_export(gpio_dir),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
    avs_address = a; avs_read = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0;
    check(tag, avs_readdata, exp);
  endtask

  initial begin
    // Reset with all pins high
    #2;
    check("rst_readdata", avs_readdata, 32'h0);
    check("rst_gpio_w", {24'h0, gpio_w}, 32'h0);
    check("rst_gpio_dir", {24'h0, gpio_dir}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    cycles(3);
    @(negedge clk); rst_n = 1'b1;
    cycles(SETTLE + 4);
    check("post_rst_irq", {31'h0, irq}, 32'h0);
    rd_check("data_in_ff", 3'd0, 32'h0000_00FF);
    rd_check("no_false_rise", 3'd7, 32'h0);

    // Output set/clear and width masking
    wr(3'd1, 32'h0F);
    check("dout_write", {24'h0, gpio_w}, 32'h0F);
    wr(3'd3, 32'hF0);
    wr(3'd4, 32'h03);
    check("dout_set_clr", {24'h0, gpio_w}, 32'hFC);
    rd_check("set_reads_0", 3'd3, 32'h0);
    rd_check("clr_reads_0", 3'd4, 32'h0);
    rd_check("dout_read", 3'd1, 32'hFC);
    wr(3'd2, 32'hFFFF_FF00);
    check("dir_masked", {24'h0, gpio_dir}, 32'h0);
    rd_check("dir_masked_rd", 3'd2, 32'h0);
    wr(3'd2, 32'h5A);
    check("dir_write", {24'h0, gpio_dir}, 32'h5A);
    check("dout_indep_dir", {24'h0, gpio_w}, 32'hFC);

    // Rising edge on pin0 with exact latency
    gpio_r = 8'h02;
    cycles(SETTLE);
    wr(3'd5, 32'h1);
    rd_check("rise_en_rd", 3'd5, 32'h1);
    gpio_r = 8'h03;                      // settled before edge k
    repeat (3 + DB) begin                // edges k .. k+2+DB: irq still low
      @(posedge clk); #1;
      check("irq_before", {31'h0, irq}, 32'h0);
    end
    avs_address = 3'd7; avs_read = 1'b1;
    @(posedge clk); #1;                  // edge k+3+DB
    avs_read = 1'b0;
    check("cap_rise", avs_readdata, 32'h1);
    check("irq_rise", {31'h0, irq}, 32'h1);
    wr(3'd7, 32'h1);
    check("irq_w1c_hold", {31'h0, irq}, 32'h1);
    cycles(1);
    check("irq_w1c_clear", {31'h0, irq}, 32'h0);
    rd_check("cap_cleared", 3'd7, 32'h0);

    // Falling edge gated by FALL_EN
    gpio_r = 8'h01;
    cycles(SETTLE);
    rd_check("fall_gated", 3'd7, 32'h0);
    check("irq_fall_gated", {31'h0, irq}, 32'h0);
    wr(3'd6, 32'h2);
    gpio_r = 8'h03;
    cycles(SETTLE);
    gpio_r = 8'h01;
    cycles(SETTLE);
    rd_check("cap_fall", 3'd7, 32'h2);
    check("irq_fall", {31'h0, irq}, 32'h1);
    wr(3'd7, 32'h2);
    cycles(1);
    check("irq_fall_clear", {31'h0, irq}, 32'h0);

    // Capture beats a same-cycle write-1-to-clear
    gpio_r = 8'h00;
    cycles(SETTLE);
    gpio_r = 8'h01;
    cycles(SETTLE);
    rd_check("cap_pre_coll", 3'd7, 32'h1);
    gpio_r = 8'h00;
    cycles(SETTLE);
    gpio_r = 8'h01;                      // settled before edge k
    repeat (2 + DB) @(posedge clk);      // edge k+1+DB
    #1;
    avs_address = 3'd7; avs_writedata = 32'h1; avs_write = 1'b1;
    @(posedge clk); #1;                  // edge k+2+DB: capture and clear together
    avs_write = 1'b0;
    check("irq_coll_0", {31'h0, irq}, 32'h1);
    cycles(1);
    check("irq_coll_1", {31'h0, irq}, 32'h1);
    rd_check("cap_coll", 3'd7, 32'h1);
    wr(3'd7, 32'h1);
    cycles(1);
    check("irq_coll_clear", {31'h0, irq}, 32'h0);

`ifdef ECU_GPIO_DEBOUNCE_EN
    // Debounce: 3-cycle glitch rejected, 4-cycle level accepted
    gpio_r = 8'h00;
    cycles(SETTLE);
    wr(3'd7, 32'hFF);
    gpio_r = 8'h01;
    cycles(3);
    gpio_r = 8'h00;
    cycles(SETTLE);
    rd_check("db_glitch_in", 3'd0, 32'h0);
    rd_check("db_glitch_cap", 3'd7, 32'h0);
    gpio_r = 8'h01;
    cycles(4);
    cycles(SETTLE);
    rd_check("db_level_in", 3'd0, 32'h1);
    rd_check("db_level_cap", 3'd7, 32'h1);
`endif

    // Mid-operation reset with pin0 high: no false rise afterwards
    gpio_r = 8'h01;
    wr(3'd1, 32'hA5);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_gpio_w", {24'h0, gpio_w}, 32'h0);
    check("midrst_irq", {31'h0, irq}, 32'h0);
    check("midrst_readdata", avs_readdata, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    wr(3'd5, 32'hFF);
    cycles(SETTLE + 4);
    rd_check("midrst_no_rise", 3'd7, 32'h0);
    rd_check("midrst_data_in", 3'd0, 32'h1);
    rd_check("midrst_rise_en", 3'd5, 32'hFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
